// File: rtl/sif_wa_responder.sv
// sif_wa_responder: single-outstanding register responder with programmable wait states,
// address/op error decode and saturating completion counters.
module sif_wa_responder #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wa_wr_s,
    input  logic              wa_rd_s,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_wdata,
    output logic [DATA_W-1:0] wa_rdata,
    output logic              wa_ack,
    output logic              wa_err,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       err_cnt
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0]      OP_IDLE   = 2'b00;
    localparam logic [1:0]      OP_READ   = 2'b01;
    localparam logic [1:0]      OP_WRITE  = 2'b10;
    localparam logic [1:0]      OP_ILL    = 2'b11;
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYC);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

    // Extra MSB on the compare so DEPTH == 2**ADDR_W never wraps.
    function automatic logic is_err(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
        is_err = (op == OP_ILL) || ({1'b0, addr} >= DEPTH_L);
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [1:0]          req_op_s;

    // Next-state, capture, memory update and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_d     = mem_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        req_op_s  = {wa_wr_s, wa_rd_s};

        case (state_q)
            S_IDLE: begin
                if (req_op_s != OP_IDLE) begin
                    op_d    = req_op_s;
                    addr_d  = wa_addr;
                    wdata_d = wa_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q > 4'd1) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = S_WAIT;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_DONE;
                if (is_err(op_q, addr_q)) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end else if (op_q == OP_WRITE) begin
                    wr_cnt_d = sat_inc(wr_cnt_q);
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_d[i] = (addr_q == ADDR_W'(i)) ? wdata_q : mem_q[i];
                    end
                end else if (op_q == OP_READ) begin
                    rd_cnt_d = sat_inc(rd_cnt_q);
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end
            S_DONE: begin
                if (!wa_wr_s && !wa_rd_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered: they rise together with entry into S_RESP.
        ack_d   = (state_d == S_RESP);
        err_d   = ack_d && is_err(op_d, addr_d);
        rdata_d = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rdata_d = (ack_d && !err_d && (op_d == OP_READ) && (addr_d == ADDR_W'(i)))
                      ? mem_q[i] : rdata_d;
        end
    end

    // State, capture registers, memory and counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            op_q      <= OP_IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            wr_cnt_q  <= 16'd0;
            rd_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
            mem_q     <= mem_d;
        end
    end

    assign wa_ack   = ack_q;
    assign wa_err   = err_q;
    assign wa_rdata = rdata_q;
    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_sif_wa_responder.sv
// Bench for sif_wa_responder: directed scenarios with literal expectations plus random
// traffic, all outputs compared every cycle against a transaction-level reference model.
module tb_sif_wa_responder;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 12;
    localparam int WAIT_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wa_wr_s = 1'b0;
    logic        wa_rd_s = 1'b0;
    logic [3:0]  wa_addr = 4'd0;
    logic [15:0] wa_wdata = 16'd0;
    logic [15:0] wa_rdata;
    logic        wa_ack;
    logic        wa_err;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] err_cnt;

    sif_wa_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wa_wr_s (wa_wr_s),
        .wa_rd_s (wa_rd_s),
        .wa_addr (wa_addr),
        .wa_wdata(wa_wdata),
        .wa_rdata(wa_rdata),
        .wa_ack  (wa_ack),
        .wa_err  (wa_err),
        .wr_cnt  (wr_cnt),
        .rd_cnt  (rd_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted at edge e is acked right after edge e+WAIT_CYC,
    // retires (mem/counters) at the following edge, then waits for both strobes low.
    logic [15:0] m_mem [16];
    logic        m_valid = 1'b0;
    logic        m_busy = 1'b0, m_hold = 1'b0;
    logic        m_ack = 1'b0, m_err = 1'b0;
    logic [15:0] m_rdata = 16'd0;
    logic [15:0] m_wr = 16'd0, m_rd = 16'd0, m_ec = 16'd0;
    logic        m_opw = 1'b0, m_opr = 1'b0;
    int          m_addr = 0;
    logic [15:0] m_wdata = 16'd0;
    int          ecount = 0;
    int          ack_edge = 0;

    task automatic model_step();
        logic bad;
        ecount++;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 16'd0;
            m_valid = 1'b1; m_busy = 1'b0; m_hold = 1'b0;
            m_wr = 16'd0; m_rd = 16'd0; m_ec = 16'd0;
            m_ack = 1'b0; m_err = 1'b0; m_rdata = 16'd0;
        end else begin
            bad = (m_opw && m_opr) || (m_addr >= DEPTH);
            if (m_ack) begin
                if (bad) begin
                    if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
                end else if (m_opw) begin
                    m_mem[m_addr] = m_wdata;
                    if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
                end else begin
                    if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
                end
                m_busy = 1'b0;
                m_hold = 1'b1;
            end else if (m_hold) begin
                if (!wa_wr_s && !wa_rd_s) m_hold = 1'b0;
            end else if (!m_busy && (wa_wr_s || wa_rd_s)) begin
                m_busy   = 1'b1;
                m_opw    = wa_wr_s;
                m_opr    = wa_rd_s;
                m_addr   = int'(wa_addr);
                m_wdata  = wa_wdata;
                ack_edge = ecount + WAIT_CYC;
            end
            bad     = (m_opw && m_opr) || (m_addr >= DEPTH);
            m_ack   = m_busy && (ecount == ack_edge);
            m_err   = m_ack && bad;
            m_rdata = (m_ack && !bad && m_opr) ? m_mem[m_addr] : 16'd0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single compare process, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cyc_ack",     32'(wa_ack),   32'(m_ack));
            chk("cyc_err",     32'(wa_err),   32'(m_err));
            chk("cyc_rdata",   32'(wa_rdata), 32'(m_rdata));
            chk("cyc_wr_cnt",  32'(wr_cnt),   32'(m_wr));
            chk("cyc_rd_cnt",  32'(rd_cnt),   32'(m_rd));
            chk("cyc_err_cnt", 32'(err_cnt),  32'(m_ec));
        end
    end

    task automatic reset_dut(input int cycles);
        rst = 1'b1; wa_wr_s = 1'b0; wa_rd_s = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic rd, input logic [3:0] a, input logic [15:0] d,
                       output int lat, output logic err, output logic [15:0] rdat,
                       output logic [15:0] rdat_next);
        wa_wr_s = wr; wa_rd_s = rd; wa_addr = a; wa_wdata = d;
        lat = 0; err = 1'b0; rdat = 16'd0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wa_ack) begin
                lat = n; err = wa_err; rdat = wa_rdata;
                break;
            end
        end
        wa_wr_s = 1'b0; wa_rd_s = 1'b0;
        wa_addr = 4'($urandom); wa_wdata = 16'($urandom);
        @(posedge clk); #1;
        rdat_next = wa_rdata;
        @(posedge clk); #1;
    endtask

    int          lat, acks;
    logic        err;
    logic [15:0] rdat, rdat_nx;

    initial begin
        reset_dut(3);
        chk("reset_ack", 32'(wa_ack), 32'd0);
        chk("reset_rdata", 32'(wa_rdata), 32'd0);
        chk("reset_cnts", {wr_cnt, rd_cnt | err_cnt}, 32'd0);

        txn(1'b1, 1'b0, 4'd3, 16'hA5A5, lat, err, rdat, rdat_nx);
        chk("wr3_latency", 32'(lat), 32'd3);
        chk("wr3_err", 32'(err), 32'd0);
        chk("wr3_wr_cnt", 32'(wr_cnt), 32'd1);

        txn(1'b0, 1'b1, 4'd3, 16'h0000, lat, err, rdat, rdat_nx);
        chk("rd3_latency", 32'(lat), 32'd3);
        chk("rd3_rdata", 32'(rdat), 32'hA5A5);
        chk("rd3_rdata_after_ack", 32'(rdat_nx), 32'd0);
        chk("rd3_rd_cnt", 32'(rd_cnt), 32'd1);

        txn(1'b1, 1'b1, 4'd3, 16'h5A5A, lat, err, rdat, rdat_nx);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_rdata", 32'(rdat), 32'd0);
        chk("ill_err_cnt", 32'(err_cnt), 32'd1);
        chk("ill_wr_cnt", 32'(wr_cnt), 32'd1);
        txn(1'b0, 1'b1, 4'd3, 16'h0000, lat, err, rdat, rdat_nx);
        chk("ill_mem_kept", 32'(rdat), 32'hA5A5);

        reset_dut(2);
        txn(1'b1, 1'b0, 4'd13, 16'h1234, lat, err, rdat, rdat_nx);
        chk("wr13_err", 32'(err), 32'd1);
        txn(1'b0, 1'b1, 4'd13, 16'h0000, lat, err, rdat, rdat_nx);
        chk("rd13_err", 32'(err), 32'd1);
        chk("rd13_rdata", 32'(rdat), 32'd0);
        chk("oob_err_cnt", 32'(err_cnt), 32'd2);
        chk("oob_wr_cnt", 32'(wr_cnt), 32'd0);

        // Strobe held well past the ack must not start a second transaction.
        wa_wr_s = 1'b1; wa_addr = 4'd5; wa_wdata = 16'h0F0F; acks = 0; lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wa_ack) begin acks++; lat = n; break; end
        end
        repeat (10) begin
            @(posedge clk); #1;
            if (wa_ack) acks++;
        end
        wa_wr_s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_latency", 32'(lat), 32'd3);
        chk("hold_one_ack", 32'(acks), 32'd1);
        chk("hold_wr_cnt", 32'(wr_cnt), 32'd1);
        txn(1'b0, 1'b1, 4'd5, 16'h0000, lat, err, rdat, rdat_nx);
        chk("hold_rd5", 32'(rdat), 32'h0F0F);

        // Reset during the wait phase of a write aborts it.
        wa_wr_s = 1'b1; wa_addr = 4'd7; wa_wdata = 16'hBEEF;
        @(posedge clk); #1;
        rst = 1'b1; wa_wr_s = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wa_ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        chk("abort_cnts", {wr_cnt, rd_cnt | err_cnt}, 32'd0);
        txn(1'b0, 1'b1, 4'd7, 16'h0000, lat, err, rdat, rdat_nx);
        chk("abort_rd7_err", 32'(err), 32'd0);
        chk("abort_rd7_rdata", 32'(rdat), 32'd0);

        // Random traffic: strobes, address and data change every cycle, rare resets.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r        = int'($urandom_range(0, 9));
            rst      = ($urandom_range(0, 199) == 0);
            wa_wr_s  = (r == 5) || (r == 6) || (r == 9);
            wa_rd_s  = (r == 7) || (r == 8) || (r == 9);
            wa_addr  = 4'($urandom);
            wa_wdata = 16'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; wa_wr_s = 1'b0; wa_rd_s = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
